// File: rtl/spi_protocol_monitor_if.sv
// SPI bus bundle shared by the driving agent and the passive protocol monitor.
interface spi_protocol_monitor_if #(
    parameter int unsigned NUM_SS = 1
);
    logic              sck;
    logic [NUM_SS-1:0] ss_n;
    logic              mosi;
    logic              miso;

    modport master (output sck, ss_n, mosi, input miso);
    modport slave  (input sck, ss_n, mosi, output miso);
    // Passive observer: sees every wire, drives none.
    modport mon    (input sck, ss_n, mosi, miso);
endinterface

// File: rtl/spi_protocol_monitor.sv
// Passive SPI bus monitor: oversamples the bus on clk, reassembles words in all four
// SPI modes and records sticky protocol errors {stable,bitcount,multi_ss,cpol}.
// Optional feature macro: SPI_MON_MISO_CAPTURE_EN (capture MISO words as well as MOSI).
module spi_protocol_monitor #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_SS      = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned SS_IDX_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              cfg_mode,
    input  logic                    cfg_lsb_first,
    input  logic                    err_clr,
    spi_protocol_monitor_if.mon     bus,
    output logic                    frame_valid,
    output logic [DATA_W-1:0]       frame_mosi,
    output logic [DATA_W-1:0]       frame_miso,
    output logic [SS_IDX_W-1:0]     frame_ss_idx,
    output logic [CNT_W-1:0]        frame_cnt,
    output logic [3:0]              err_flags,
    output logic                    busy
);
    localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned WAIT_W = 2;

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE, ERROR} state_e;

    logic [SYNC_STAGES-1:0]             sck_sync_q;
    logic [SYNC_STAGES-1:0][NUM_SS-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0]             mosi_sync_q;
    logic                               sck_s;
    logic [NUM_SS-1:0]                  ss_s;
    logic                               mosi_s;

    state_e                state_q, state_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                  sck_prev_q, mosi_prev_q;
    logic [1:0]            mode_q, mode_d;
    logic                  lsb_q, lsb_d;
    logic [SS_IDX_W-1:0]   sel_q, sel_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]     mosi_sreg_q, mosi_sreg_d;
    logic                  frame_valid_q, frame_valid_d;
    logic [DATA_W-1:0]     frame_mosi_q, frame_mosi_d;
    logic [SS_IDX_W-1:0]   frame_ss_idx_q, frame_ss_idx_d;
    logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic [3:0]            err_q, err_d;
    logic                  busy_q, busy_d;

    logic                  sample_c;
    logic [DATA_W-1:0]     mosi_word_c;

`ifdef SPI_MON_MISO_CAPTURE_EN
    logic [SYNC_STAGES-1:0] miso_sync_q;
    logic                   miso_s;
    logic [DATA_W-1:0]      miso_sreg_q, miso_sreg_d;
    logic [DATA_W-1:0]      frame_miso_q, frame_miso_d;
    logic [DATA_W-1:0]      miso_word_c;

    assign miso_s     = miso_sync_q[SYNC_STAGES-1];
    assign frame_miso = frame_miso_q;

    // MISO synchroniser and capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_sync_q  <= '0;
            miso_sreg_q  <= '0;
            frame_miso_q <= '0;
        end else begin
            miso_sync_q  <= {miso_sync_q[SYNC_STAGES-2:0], bus.miso};
            miso_sreg_q  <= miso_sreg_d;
            frame_miso_q <= frame_miso_d;
        end
    end
`else
    logic unused_miso;
    assign unused_miso = bus.miso;
    assign frame_miso  = '0;
`endif

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Input synchronisers; selects reset inactive so the bus looks idle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
        end
    end

    // FSM and datapath state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= WAIT_IDLE;
            wait_cnt_q     <= '0;
            sck_prev_q     <= 1'b0;
            mosi_prev_q    <= 1'b0;
            mode_q         <= '0;
            lsb_q          <= 1'b0;
            sel_q          <= '0;
            bit_cnt_q      <= '0;
            mosi_sreg_q    <= '0;
            frame_valid_q  <= 1'b0;
            frame_mosi_q   <= '0;
            frame_ss_idx_q <= '0;
            frame_cnt_q    <= '0;
            err_q          <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            sck_prev_q     <= sck_s;
            mosi_prev_q    <= mosi_s;
            mode_q         <= mode_d;
            lsb_q          <= lsb_d;
            sel_q          <= sel_d;
            bit_cnt_q      <= bit_cnt_d;
            mosi_sreg_q    <= mosi_sreg_d;
            frame_valid_q  <= frame_valid_d;
            frame_mosi_q   <= frame_mosi_d;
            frame_ss_idx_q <= frame_ss_idx_d;
            frame_cnt_q    <= frame_cnt_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
        end
    end

    // Sample-edge detection relative to the latched mode, and next word candidates.
    always_comb begin
        sample_c    = 1'b0;
        if (mode_q[0]) sample_c = (sck_prev_q != mode_q[1]) && (sck_s == mode_q[1]);
        else           sample_c = (sck_prev_q == mode_q[1]) && (sck_s != mode_q[1]);
        mosi_word_c = lsb_q ? {mosi_s, mosi_sreg_q[DATA_W-1:1]}
                            : {mosi_sreg_q[DATA_W-2:0], mosi_s};
`ifdef SPI_MON_MISO_CAPTURE_EN
        miso_word_c = lsb_q ? {miso_s, miso_sreg_q[DATA_W-1:1]}
                            : {miso_sreg_q[DATA_W-2:0], miso_s};
`endif
    end

    // Next-state, frame assembly and error-flag logic.
    always_comb begin
        int unsigned         num_low;
        logic [SS_IDX_W-1:0] low_idx;
        logic                others_low;
        logic                sel_high;
        logic [3:0]          new_err;

        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        mode_d         = mode_q;
        lsb_d          = lsb_q;
        sel_d          = sel_q;
        bit_cnt_d      = bit_cnt_q;
        mosi_sreg_d    = mosi_sreg_q;
        frame_valid_d  = 1'b0;
        frame_mosi_d   = frame_mosi_q;
        frame_ss_idx_d = frame_ss_idx_q;
        frame_cnt_d    = frame_cnt_q;
        new_err        = '0;
        num_low        = 0;
        low_idx        = '0;
        others_low     = 1'b0;
        sel_high       = 1'b1;
`ifdef SPI_MON_MISO_CAPTURE_EN
        miso_sreg_d    = miso_sreg_q;
        frame_miso_d   = frame_miso_q;
`endif

        for (int i = 0; i < int'(NUM_SS); i++) begin
            if (!ss_s[i]) begin
                num_low = num_low + 1;
                low_idx = SS_IDX_W'(i);
                if (SS_IDX_W'(i) != sel_q) others_low = 1'b1;
            end
            if (SS_IDX_W'(i) == sel_q) sel_high = ss_s[i];
        end

        case (state_q)
            // Hold off until the synchroniser has flushed real pin values, then
            // wait for a fully idle bus so a frame in flight at reset is ignored.
            WAIT_IDLE: begin
                if (wait_cnt_q < WAIT_W'(SYNC_STAGES)) wait_cnt_d = wait_cnt_q + 1'b1;
                else if (&ss_s)                          state_d    = IDLE;
            end
            IDLE: begin
                if (num_low == 1) begin
                    state_d   = ACTIVE;
                    mode_d    = cfg_mode;
                    lsb_d     = cfg_lsb_first;
                    sel_d     = low_idx;
                    bit_cnt_d = '0;
                    if (sck_s != cfg_mode[1]) new_err[0] = 1'b1;
                end else if (num_low > 1) begin
                    state_d    = ERROR;
                    new_err[1] = 1'b1;
                end
            end
            ACTIVE: begin
                if (others_low) begin
                    state_d    = ERROR;
                    new_err[1] = 1'b1;
                end else if (sel_high) begin
                    if (bit_cnt_q != '0) new_err[2] = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else if (sample_c) begin
                    if (mosi_s != mosi_prev_q) new_err[3] = 1'b1;
                    mosi_sreg_d = mosi_word_c;
`ifdef SPI_MON_MISO_CAPTURE_EN
                    miso_sreg_d = miso_word_c;
`endif
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                        bit_cnt_d      = '0;
                        frame_valid_d  = 1'b1;
                        frame_mosi_d   = mosi_word_c;
                        frame_ss_idx_d = sel_q;
                        if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
`ifdef SPI_MON_MISO_CAPTURE_EN
                        frame_miso_d   = miso_word_c;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ERROR: begin
                if (&ss_s) state_d = IDLE;
            end
            default: state_d = WAIT_IDLE;
        endcase

        // A clear in the same cycle as a new error keeps the new flag.
        err_d  = (err_clr ? 4'b0000 : err_q) | new_err;
        busy_d = (state_d == ACTIVE);
    end

    assign frame_valid  = frame_valid_q;
    assign frame_mosi   = frame_mosi_q;
    assign frame_ss_idx = frame_ss_idx_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_flags    = err_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_spi_protocol_monitor.sv
// Randomised self-checking bench for spi_protocol_monitor (DATA_W=8, NUM_SS=2).
module tb_spi_protocol_monitor;
    localparam int unsigned DW    = 8;
    localparam int unsigned NSS   = 2;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned CW    = 16;
    localparam int          CLK_P = 10;
    localparam int          H     = 4;   // SCK half-period in clk cycles

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     cfg_mode;
    logic           cfg_lsb_first;
    logic           err_clr;
    logic           frame_valid;
    logic [DW-1:0]  frame_mosi;
    logic [DW-1:0]  frame_miso;
    logic [0:0]     frame_ss_idx;
    logic [CW-1:0]  frame_cnt;
    logic [3:0]     err_flags;
    logic           busy;

    int  errors = 0;
    int  checks = 0;
    int  fv_count = 0;
    int  exp_cnt = 0;
    time fv_t = 0;
    time samp_t = 0;

    spi_protocol_monitor_if #(.NUM_SS(NSS)) bus();

    spi_protocol_monitor #(.DATA_W(DW), .NUM_SS(NSS), .SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_lsb_first(cfg_lsb_first),
        .err_clr(err_clr), .bus(bus), .frame_valid(frame_valid), .frame_mosi(frame_mosi),
        .frame_miso(frame_miso), .frame_ss_idx(frame_ss_idx), .frame_cnt(frame_cnt),
        .err_flags(err_flags), .busy(busy)
    );

    always #(CLK_P/2) clk = ~clk;

    // Count frame_valid pulses and note when the latest one was seen.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_count = fv_count + 1;
            fv_t     = $time;
        end
    end

    // Reference: the last complete word of a transfer is the word that was sent.
    function automatic logic [DW-1:0] last_word(input logic [31:0] data, input int nbits);
        int base;
        base = ((nbits / DW) - 1) * DW;
        return data[base +: DW];
    endfunction

    function automatic logic [DW-1:0] exp_miso(input logic [31:0] data, input int nbits);
`ifdef SPI_MON_MISO_CAPTURE_EN
        return last_word(data, nbits);
`else
        return (data[0] & 1'b0) ? '1 : '0;
`endif
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sel(input int idx);
        bus.ss_n      = '1;
        bus.ss_n[idx] = 1'b0;
        wait_clk(H);
    endtask

    task automatic desel();
        bus.ss_n = '1;
        wait_clk(3 * H);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        wait_clk(2);
    endtask

    // Drive nbits; word j occupies data[j*DW +: DW], each word in its own bit order.
    task automatic shift(input logic [1:0] mode, input bit lsb, input logic [31:0] md,
                         input logic [31:0] sd, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            int idx;
            idx = lsb ? k : (k / DW) * DW + (DW - 1 - (k % DW));
            if (!mode[0]) begin
                bus.mosi = md[idx];
                bus.miso = sd[idx];
                wait_clk(H);
                bus.sck = ~mode[1];
                samp_t  = $time;
                wait_clk(H);
                bus.sck = mode[1];
            end else begin
                wait_clk(H);
                bus.sck  = ~mode[1];
                bus.mosi = md[idx];
                bus.miso = sd[idx];
                wait_clk(H);
                bus.sck = mode[1];
                samp_t  = $time;
            end
        end
        wait_clk(H);
    endtask

    task automatic xfer(input logic [1:0] mode, input bit lsb, input int idx,
                        input logic [31:0] md, input logic [31:0] sd, input int nbits);
        cfg_mode      = mode;
        cfg_lsb_first = lsb;
        bus.sck       = mode[1];
        wait_clk(H);
        sel(idx);
        shift(mode, lsb, md, sd, nbits);
        desel();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_mode = 2'd0; cfg_lsb_first = 1'b0; err_clr = 1'b0;
        bus.sck = 1'b0; bus.ss_n = '1; bus.mosi = 1'b0; bus.miso = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(5);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b expected 0", frame_valid); end
        checks++; if (frame_mosi !== '0) begin errors++; $display("FAIL reset_mosi: got %h expected 00", frame_mosi); end
        checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", frame_cnt); end
        checks++; if (err_flags !== 4'b0000) begin errors++; $display("FAIL reset_err: got %b expected 0000", err_flags); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        exp_cnt = 0;
    endtask

    task automatic test_mode0();
        int f0;
        f0 = fv_count;
        xfer(2'd0, 1'b0, 0, 32'hA5, 32'h5A, 8);
        exp_cnt++;
        checks++; if (fv_count - f0 != 1) begin errors++; $display("FAIL m0_frames: got %0d expected 1", fv_count - f0); end
        checks++; if (frame_mosi !== 8'hA5) begin errors++; $display("FAIL m0_mosi: got %h expected a5", frame_mosi); end
        checks++; if (frame_miso !== exp_miso(32'h5A, 8)) begin errors++; $display("FAIL m0_miso: got %h expected %h", frame_miso, exp_miso(32'h5A, 8)); end
        checks++; if (frame_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL m0_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
        checks++; if (frame_ss_idx !== 1'b0) begin errors++; $display("FAIL m0_idx: got %0d expected 0", frame_ss_idx); end
        checks++; if (err_flags !== 4'b0000) begin errors++; $display("FAIL m0_err: got %b expected 0000", err_flags); end
        checks++; if (fv_t - samp_t != time'((SYNC + 1) * CLK_P)) begin errors++; $display("FAIL m0_latency: got %0t expected %0d", fv_t - samp_t, (SYNC + 1) * CLK_P); end
    endtask

    task automatic test_modes();
        for (int m = 1; m < 4; m++) begin
            for (int r = 0; r < 3; r++) begin
                logic [31:0] md, sd;
                bit          lsb;
                int          idx, f0;
                md  = (r == 0) ? 32'h3C : 32'($urandom_range(0, 255));
                sd  = 32'($urandom_range(0, 255));
                lsb = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                idx = $urandom_range(0, NSS - 1);
                f0  = fv_count;
                xfer(2'(m), lsb, idx, md, sd, 8);
                exp_cnt++;
                checks++; if (fv_count - f0 != 1) begin errors++; $display("FAIL modes_frames m%0d: got %0d expected 1", m, fv_count - f0); end
                checks++; if (frame_mosi !== md[7:0]) begin errors++; $display("FAIL modes_mosi m%0d lsb%0d: got %h expected %h", m, lsb, frame_mosi, md[7:0]); end
                checks++; if (frame_miso !== exp_miso(sd, 8)) begin errors++; $display("FAIL modes_miso m%0d: got %h expected %h", m, frame_miso, exp_miso(sd, 8)); end
                checks++; if (frame_ss_idx !== 1'(idx)) begin errors++; $display("FAIL modes_idx m%0d: got %0d expected %0d", m, frame_ss_idx, idx); end
                checks++; if (frame_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL modes_cnt m%0d: got %0d expected %0d", m, frame_cnt, exp_cnt); end
                checks++; if (err_flags !== 4'b0000) begin errors++; $display("FAIL modes_err m%0d: got %b expected 0000", m, err_flags); end
            end
        end
    endtask

    task automatic test_cpol_err();
        int f0;
        f0 = fv_count;
        cfg_mode = 2'd2; cfg_lsb_first = 1'b0;
        bus.sck = 1'b0;
        wait_clk(H);
        sel(0);
        bus.sck = 1'b1;
        wait_clk(H);
        desel();
        checks++; if (err_flags !== 4'b0001) begin errors++; $display("FAIL cpol_err: got %b expected 0001", err_flags); end
        checks++; if (fv_count != f0) begin errors++; $display("FAIL cpol_frames: got %0d expected 0", fv_count - f0); end
        pulse_clr();
        checks++; if (err_flags !== 4'b0000) begin errors++; $display("FAIL cpol_clr: got %b expected 0000", err_flags); end
    endtask

    task automatic test_multi_ss();
        int f0;
        f0 = fv_count;
        cfg_mode = 2'd0; bus.sck = 1'b0;
        wait_clk(H);
        bus.ss_n = 2'b00;
        wait_clk(H);
        shift(2'd0, 1'b0, 32'($urandom_range(0, 255)), 32'h0, 8);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multi_busy: got %b expected 0", busy); end
        desel();
        checks++; if (err_flags !== 4'b0010) begin errors++; $display("FAIL multi_err: got %b expected 0010", err_flags); end
        checks++; if (fv_count != f0) begin errors++; $display("FAIL multi_frames: got %0d expected 0", fv_count - f0); end
        checks++; if (frame_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL multi_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
        pulse_clr();
        // Second select falling inside an active frame.
        sel(0);
        shift(2'd0, 1'b0, 32'($urandom_range(0, 255)), 32'h0, 3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL active_busy: got %b expected 1", busy); end
        bus.ss_n[1] = 1'b0;
        wait_clk(H);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy: got %b expected 0", busy); end
        checks++; if (err_flags !== 4'b0010) begin errors++; $display("FAIL other_fall_err: got %b expected 0010", err_flags); end
        desel();
        pulse_clr();
        checks++; if (err_flags !== 4'b0000) begin errors++; $display("FAIL multi_clr: got %b expected 0000", err_flags); end
    endtask

    task automatic test_bitcount();
        int f0;
        logic [31:0] md, sd;
        bit lsb;
        logic [1:0] mode;
        f0 = fv_count;
        xfer(2'd0, 1'b0, 0, 32'($urandom_range(0, 255)), 32'h0, 5);
        checks++; if (err_flags !== 4'b0100) begin errors++; $display("FAIL short_err: got %b expected 0100", err_flags); end
        checks++; if (fv_count != f0) begin errors++; $display("FAIL short_frames: got %0d expected 0", fv_count - f0); end
        pulse_clr();
        md   = 32'($urandom_range(0, 65535));
        sd   = 32'($urandom_range(0, 65535));
        lsb  = 1'($urandom_range(0, 1));
        mode = 2'($urandom_range(0, 3));
        f0   = fv_count;
        xfer(mode, lsb, 1, md, sd, 16);
        exp_cnt += 2;
        checks++; if (fv_count - f0 != 2) begin errors++; $display("FAIL b2b_frames: got %0d expected 2", fv_count - f0); end
        checks++; if (frame_mosi !== last_word(md, 16)) begin errors++; $display("FAIL b2b_mosi: got %h expected %h", frame_mosi, last_word(md, 16)); end
        checks++; if (frame_miso !== exp_miso(sd, 16)) begin errors++; $display("FAIL b2b_miso: got %h expected %h", frame_miso, exp_miso(sd, 16)); end
        checks++; if (frame_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
        checks++; if (err_flags !== 4'b0000) begin errors++; $display("FAIL b2b_err: got %b expected 0000", err_flags); end
    endtask

    task automatic test_stability();
        cfg_mode = 2'd0; bus.sck = 1'b0;
        wait_clk(H);
        sel(0);
        bus.mosi = ~bus.mosi;
        bus.sck  = 1'b1;
        wait_clk(H);
        bus.sck  = 1'b0;
        wait_clk(H);
        desel();
        checks++; if (err_flags !== 4'b1100) begin errors++; $display("FAIL stable_err: got %b expected 1100", err_flags); end
        pulse_clr();
    endtask

    task automatic test_reset_midframe();
        int f0;
        logic [31:0] md;
        f0 = fv_count;
        cfg_mode = 2'd0; cfg_lsb_first = 1'b0; bus.sck = 1'b0;
        wait_clk(H);
        sel(0);
        shift(2'd0, 1'b0, 32'hC3, 32'h0, 4);
        rst_n = 1'b0;
        wait_clk(2);
        exp_cnt = 0;
        checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL rst_mid_cnt: got %0d expected 0", frame_cnt); end
        rst_n = 1'b1;
        shift(2'd0, 1'b0, 32'h0FFF, 32'h0, 12);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        desel();
        checks++; if (fv_count != f0) begin errors++; $display("FAIL rst_mid_frames: got %0d expected 0", fv_count - f0); end
        md = 32'($urandom_range(0, 255));
        xfer(2'd0, 1'b0, 0, md, 32'h0, 8);
        exp_cnt++;
        checks++; if (fv_count - f0 != 1) begin errors++; $display("FAIL rst_after_frames: got %0d expected 1", fv_count - f0); end
        checks++; if (frame_mosi !== md[7:0]) begin errors++; $display("FAIL rst_after_mosi: got %h expected %h", frame_mosi, md[7:0]); end
        checks++; if (frame_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL rst_after_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_cpol_err();
        test_multi_ss();
        test_bitcount();
        test_stability();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
